// File: rtl/dlx_pkg.sv
// Shared register-file types for the writeback arbiter.
// Holds widths, address/data types and the buffered result entry.
package dlx_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    logic      alive;
    reg_addr_t rd;
    word_t     data;
  } wb_entry_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between result producers, the writeback arbiter and the register file.
// The arbiter connects through the slave modport; the environment uses master.
interface wb_arbiter_if;
  import dlx_pkg::*;

  logic      pipe_valid;
  reg_addr_t pipe_rd;
  word_t     pipe_data;

  logic      mc_valid;
  logic      mc_ready;
  reg_addr_t mc_rd;
  word_t     mc_data;

  logic      WB;
  reg_addr_t Rd;
  word_t     reg_s;
  logic      stall_pipe;

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data,
    input  mc_valid, mc_rd, mc_data,
    output mc_ready,
    output WB, Rd, reg_s, stall_pipe
  );

  modport master (
    output pipe_valid, pipe_rd, pipe_data,
    output mc_valid, mc_rd, mc_data,
    input  mc_ready,
    input  WB, Rd, reg_s, stall_pipe
  );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// Multi-cycle result buffer: DEPTH-entry circular FIFO of wb_entry_t.
// A squash input kills every stored entry whose rd matches (CAM over all slots).
module wb_fifo
  import dlx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  wb_entry_t push_entry_i,
  input  logic      pop_i,
  input  logic      squash_i,
  input  reg_addr_t squash_rd_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (squash_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (mem_q[i].rd == squash_rd_i) mem_q[i].alive <= 1'b0;
        end
      end
      // The pushed entry already carries its own alive bit; it must not be squashed again.
      if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority over buffered mul/div results.
// Optional starvation guard enabled by defining WB_STARVE_GUARD_EN.
module wb_arbiter
  import dlx_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);

  wb_entry_t head;
  wb_entry_t push_entry;
  logic      fifo_full, fifo_empty;
  logic      push, pop, squash;

  logic      wb_q, wb_d;
  reg_addr_t rd_q, rd_d;
  word_t     data_q, data_d;

  assign bus.mc_ready = !fifo_full && !rst;
  assign push         = bus.mc_valid && bus.mc_ready;

  always_comb begin
    wb_d             = 1'b0;
    rd_d             = rd_q;
    data_d           = data_q;
    pop              = 1'b0;
    squash           = 1'b0;
    push_entry.alive = 1'b1;
    push_entry.rd    = bus.mc_rd;
    push_entry.data  = bus.mc_data;
    if (bus.pipe_valid) begin
      wb_d   = (bus.pipe_rd != REG_ZERO);
      rd_d   = bus.pipe_rd;
      data_d = bus.pipe_data;
      squash = (bus.pipe_rd != REG_ZERO);
      // A same-cycle mc result to the same register is older than the pipeline write.
      if (squash && (bus.mc_rd == bus.pipe_rd)) push_entry.alive = 1'b0;
    end else if (!fifo_empty) begin
      pop    = 1'b1;
      wb_d   = head.alive && (head.rd != REG_ZERO);
      rd_d   = head.rd;
      data_d = head.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      wb_q   <= wb_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  assign bus.WB    = wb_q;
  assign bus.Rd    = rd_q;
  assign bus.reg_s = data_q;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_entry_i(push_entry),
    .pop_i       (pop),
    .squash_i    (squash),
    .squash_rd_i (bus.pipe_rd),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

`ifdef WB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              stall_q, stall_d;

  always_comb begin
    wait_d  = wait_q;
    stall_d = 1'b0;
    if (pop) begin
      wait_d = '0;
    end else if (bus.pipe_valid && !fifo_empty) begin
      if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
        stall_d = 1'b1;
        wait_d  = '0;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  assign bus.stall_pipe = stall_q;

  // The pipeline still wins if it ignores the stall, but that breaks its contract.
  a_stall_honoured: assert property (@(posedge clk) disable iff (rst) !(stall_q && bus.pipe_valid));
`else
  assign bus.stall_pipe = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-level model predicts every cycle's write port.
// Stimulus pushes predictions; an independent negedge monitor pops and compares.
module tb_wb_arbiter;
  import dlx_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    bit          wb;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    bit          alive;
    logic [4:0]  rd;
    logic [31:0] data;
  } buf_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if bus ();

  wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t exp_q[$];
  buf_t model_q[$];
  exp_t pend;
  bit   pend_ok;
  int   checks;
  int   failures;

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.pipe_valid = 1'b0;
    bus.pipe_rd    = '0;
    bus.pipe_data  = '0;
    bus.mc_valid   = 1'b0;
    bus.mc_rd      = '0;
    bus.mc_data    = '0;
  endtask

  // One clock of stimulus plus the model's prediction of the write issued at the coming edge.
  task automatic step(input bit pv, input logic [4:0] prd, input logic [31:0] pdata,
                      input bit mv, input logic [4:0] mrd, input logic [31:0] mdata);
    bit   acc;
    buf_t e;
    buf_t n;
    @(posedge clk);
    if (pend_ok) exp_q.push_back(pend);
    #1;
    bus.pipe_valid = pv;
    bus.pipe_rd    = prd;
    bus.pipe_data  = pdata;
    bus.mc_valid   = mv;
    bus.mc_rd      = mrd;
    bus.mc_data    = mdata;
    #1;
    check1("mc_ready", bus.mc_ready, model_q.size() < DEPTH);
    check1("stall_pipe", bus.stall_pipe, 1'b0);
    acc = mv && (model_q.size() < DEPTH);
    pend.wb   = 1'b0;
    pend.rd   = '0;
    pend.data = '0;
    if (pv) begin
      if (prd != 5'd0) begin
        foreach (model_q[i]) if (model_q[i].rd == prd) model_q[i].alive = 1'b0;
        pend.wb   = 1'b1;
        pend.rd   = prd;
        pend.data = pdata;
      end
    end else if (model_q.size() > 0) begin
      e = model_q.pop_front();
      if (e.alive && e.rd != 5'd0) begin
        pend.wb   = 1'b1;
        pend.rd   = e.rd;
        pend.data = e.data;
      end
    end
    if (acc) begin
      n.alive = !(pv && prd != 5'd0 && mrd == prd);
      n.rd    = mrd;
      n.data  = mdata;
      model_q.push_back(n);
    end
    pend_ok = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    pend_ok = 1'b0;
    #1;
    rst = 1'b1;
    idle_inputs();
    #1;
    check1("rst_WB", bus.WB, 1'b0);
    check1("rst_mc_ready", bus.mc_ready, 1'b0);
    check1("rst_stall", bus.stall_pipe, 1'b0);
    checks++;
    if (bus.Rd !== 5'd0 || bus.reg_s !== 32'd0) begin
      failures++;
      $display("FAIL rst_outputs actual Rd=%0d reg_s=%0d required 0/0", bus.Rd, bus.reg_s);
    end
    model_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (!rst && exp_q.size() > 0) begin
      x = exp_q.pop_front();
      checks++;
      if (bus.WB !== x.wb) begin
        failures++;
        $display("FAIL wb_en actual=%b required=%b (rd=%0d) t=%0t", bus.WB, x.wb, x.rd, $time);
      end else if (x.wb) begin
        checks++;
        if (bus.Rd !== x.rd || bus.reg_s !== x.data) begin
          failures++;
          $display("FAIL wb_data actual rd=%0d data=%0d required rd=%0d data=%0d t=%0t",
                   bus.Rd, bus.reg_s, x.rd, x.data, $time);
        end
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    pend_ok  = 1'b0;
    rst      = 1'b1;
    idle_inputs();
    #2;
    check1("init_WB", bus.WB, 1'b0);
    check1("init_mc_ready", bus.mc_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Pipeline-only writes, including r0 suppression.
    step(1, 5'd7, 32'd111111, 0, 5'd0, 32'd0);
    step(1, 5'd0, 32'd5, 0, 5'd0, 32'd0);
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

    // Multi-cycle only: written two edges after the push.
    step(0, 5'd0, 32'd0, 1, 5'd3, 32'd222222);
    repeat (3) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

    // Backpressure: pipeline busy, DEPTH+1 offers, then drain in order.
    for (int i = 0; i < DEPTH + 1; i++)
      step(1, 5'd20, 32'd900 + i, 1, 5'(i + 1), 32'd1000 + i);
    step(1, 5'd20, 32'd999, 0, 5'd0, 32'd0);
    repeat (DEPTH + 2) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

    // Squash of a buffered entry by a younger pipeline write.
    step(1, 5'd21, 32'd1, 1, 5'd13, 32'd333333);
    step(1, 5'd13, 32'd444444, 0, 5'd0, 32'd0);
    repeat (2) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

    // Simultaneous pipeline and mc writes to the same register.
    step(1, 5'd10, 32'd555, 1, 5'd10, 32'd666);
    repeat (2) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

    // Reset with two entries buffered and a write in flight.
    step(1, 5'd22, 32'd7, 1, 5'd4, 32'd44);
    step(1, 5'd23, 32'd8, 1, 5'd5, 32'd55);
    step(1, 5'd24, 32'd9, 0, 5'd0, 32'd0);
    do_reset();
    repeat (4) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

    // Randomized traffic with a narrow rd range to provoke squashes.
    for (int c = 0; c < 2000; c++) begin
      step($urandom_range(0, 99) < 55, 5'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 99) < 50, 5'($urandom_range(0, 15)), $urandom);
    end
    repeat (DEPTH + 3) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

    @(posedge clk);
    if (pend_ok) exp_q.push_back(pend);
    pend_ok = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
